// File: rtl/pyrm_dcache_pkg.sv
// Shared types and decode helpers for the dcache read-modify-write controller.
package pyrm_dcache_pkg;

  typedef logic [2:0] dc_state_t;

  localparam dc_state_t ST_IDLE  = 3'd0;
  localparam dc_state_t ST_READ  = 3'd1;
  localparam dc_state_t ST_CAPT  = 3'd2;
  localparam dc_state_t ST_WRITE = 3'd3;
  localparam dc_state_t ST_RESP  = 3'd4;

  localparam logic [2:0] FUNCT3_LOAD_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LOAD_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LOAD_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LOAD_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LOAD_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LOAD_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LOAD_LWU = 3'b110;

  localparam logic [2:0] FUNCT3_STORE_SB = 3'b000;
  localparam logic [2:0] FUNCT3_STORE_SH = 3'b001;
  localparam logic [2:0] FUNCT3_STORE_SW = 3'b010;
  localparam logic [2:0] FUNCT3_STORE_SD = 3'b011;

  // Access size in bytes from funct3[1:0].
  function automatic logic [3:0] dc_size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    dc_size_bytes = 4'd1;
      2'd1:    dc_size_bytes = 4'd2;
      2'd2:    dc_size_bytes = 4'd4;
      default: dc_size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/pyrm_dcache_align.sv
// Combinational byte-lane alignment: store merge into a 128-bit line and load extract/extend.
module pyrm_dcache_align
  import pyrm_dcache_pkg::*;
(
  input  logic [127:0] line,
  input  logic [2:0]   off,
  input  logic [2:0]   f3,
  input  logic [63:0]  data,
  output logic [127:0] merged,
  output logic [63:0]  ld_data
);

  logic [5:0]   sh;
  logic [63:0]  size_mask;
  logic [127:0] mask;
  logic [63:0]  xw;

  assign sh = {off, 3'b000};

  always_comb begin
    size_mask = 64'd0;
    case (dc_size_bytes(f3))
      4'd1:    size_mask = 64'h0000_0000_0000_00ff;
      4'd2:    size_mask = 64'h0000_0000_0000_ffff;
      4'd4:    size_mask = 64'h0000_0000_ffff_ffff;
      default: size_mask = 64'hffff_ffff_ffff_ffff;
    endcase
  end

  // Shifting within 128 bits lets an access at any offset spill into the second word.
  assign mask   = {64'd0, size_mask} << sh;
  assign merged = (line & ~mask) | (({64'd0, data} << sh) & mask);
  assign xw     = 64'(line >> sh);

  always_comb begin
    ld_data = 64'd0;
    case (f3)
      FUNCT3_LOAD_LB:  ld_data = {{56{xw[7]}},  xw[7:0]};
      FUNCT3_LOAD_LH:  ld_data = {{48{xw[15]}}, xw[15:0]};
      FUNCT3_LOAD_LW:  ld_data = {{32{xw[31]}}, xw[31:0]};
      FUNCT3_LOAD_LD:  ld_data = xw;
      FUNCT3_LOAD_LBU: ld_data = {56'd0, xw[7:0]};
      FUNCT3_LOAD_LHU: ld_data = {48'd0, xw[15:0]};
      FUNCT3_LOAD_LWU: ld_data = {32'd0, xw[31:0]};
      default:         ld_data = 64'd0;
    endcase
  end

endmodule

// File: rtl/pyrm_dcache_rmw_ctrl.sv
// One-at-a-time load/store sequencer over a two-word dcache array: read, capture, merge/write or respond.
module pyrm_dcache_rmw_ctrl
  import pyrm_dcache_pkg::*;
#(
  parameter int DC_IDX_W = 11
) (
  input  logic                clk,
  input  logic                reset_pyri,
  input  logic [63:0]         req_addr_pyri,
  input  logic [63:0]         req_data_pyri,
  input  logic [2:0]          req_f3_pyri,
  input  logic                req_store_pyri,
  input  logic                req_valid_pyri,
  output logic                req_retry_pyro,
  output logic [63:0]         resp_data_pyro,
  output logic                resp_valid_pyro,
  input  logic                resp_retry_pyri,
  output logic [DC_IDX_W-1:0] dc_idx_pyro,
  output logic                dc_rd_pyro,
  input  logic [63:0]         dc_rdata1_pyri,
  input  logic [63:0]         dc_rdata2_pyri,
  output logic [63:0]         dc_wdata1_pyro,
  output logic [63:0]         dc_wdata2_pyro,
  output logic                dc_we_pyro,
  output logic                busy_pyro
);

  dc_state_t           state;
  logic [DC_IDX_W-1:0] idx_q;
  logic [2:0]          off_q;
  logic [2:0]          f3_q;
  logic [63:0]         data_q;
  logic                store_q;
  logic [127:0]        line_q;
  logic [63:0]         resp_q;

  logic [127:0]        aln_line;
  logic [127:0]        merged;
  logic [63:0]         ld_data;
  logic                unused_addr;

  assign unused_addr = ^req_addr_pyri[63:DC_IDX_W+3];

  // Loads extract straight from the returning words so the result is registered in CAPT.
  assign aln_line = (state == ST_CAPT) ? {dc_rdata2_pyri, dc_rdata1_pyri} : line_q;

  pyrm_dcache_align u_align (
    .line    (aln_line),
    .off     (off_q),
    .f3      (f3_q),
    .data    (data_q),
    .merged  (merged),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk or negedge reset_pyri) begin
    if (!reset_pyri) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      off_q   <= 3'd0;
      f3_q    <= 3'd0;
      data_q  <= 64'd0;
      store_q <= 1'b0;
      line_q  <= 128'd0;
      resp_q  <= 64'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_pyri) begin
            idx_q   <= req_addr_pyri[DC_IDX_W+2:3];
            off_q   <= req_addr_pyri[2:0];
            f3_q    <= req_f3_pyri;
            data_q  <= req_data_pyri;
            store_q <= req_store_pyri;
            state   <= ST_READ;
          end
        end
        ST_READ: state <= ST_CAPT;
        ST_CAPT: begin
          line_q <= {dc_rdata2_pyri, dc_rdata1_pyri};
          if (store_q) begin
            // Stores with funct3[2] set are illegal: retire without writing.
            state <= f3_q[2] ? ST_IDLE : ST_WRITE;
          end else begin
            resp_q <= ld_data;
            state  <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        ST_RESP: begin
          if (!resp_retry_pyri) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_retry_pyro  = (state != ST_IDLE);
  assign busy_pyro       = (state != ST_IDLE);
  assign dc_idx_pyro     = idx_q;
  assign dc_rd_pyro      = (state == ST_READ);
  assign dc_we_pyro      = (state == ST_WRITE);
  assign dc_wdata1_pyro  = dc_we_pyro ? merged[63:0]   : 64'd0;
  assign dc_wdata2_pyro  = dc_we_pyro ? merged[127:64] : 64'd0;
  assign resp_valid_pyro = (state == ST_RESP);
  assign resp_data_pyro  = resp_q;

endmodule

// File: tb/tb_pyrm_dcache_rmw_ctrl.sv
// Directed bench for pyrm_dcache_rmw_ctrl with a behavioural two-word dcache array.
module tb_pyrm_dcache_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_data = 64'd0;
  logic [2:0]  req_f3 = 3'd0;
  logic        req_store = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_retry;
  logic [63:0] resp_data;
  logic        resp_valid;
  logic        resp_retry = 1'b0;
  logic [10:0] dc_idx;
  logic        dc_rd;
  logic [63:0] rd1 = 64'd0;
  logic [63:0] rd2 = 64'd0;
  logic [63:0] w1, w2;
  logic        dc_we;
  logic        busy;

  logic [63:0] mem [0:2047];
  logic        pl_we = 1'b0;
  logic [10:0] pl_idx = 11'd0;
  logic [63:0] pl_data = 64'd0;
  int          we_cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pyrm_dcache_rmw_ctrl #(.DC_IDX_W(11)) dut (
    .clk             (clk),
    .reset_pyri      (rst_n),
    .req_addr_pyri   (req_addr),
    .req_data_pyri   (req_data),
    .req_f3_pyri     (req_f3),
    .req_store_pyri  (req_store),
    .req_valid_pyri  (req_valid),
    .req_retry_pyro  (req_retry),
    .resp_data_pyro  (resp_data),
    .resp_valid_pyro (resp_valid),
    .resp_retry_pyri (resp_retry),
    .dc_idx_pyro     (dc_idx),
    .dc_rd_pyro      (dc_rd),
    .dc_rdata1_pyri  (rd1),
    .dc_rdata2_pyri  (rd2),
    .dc_wdata1_pyro  (w1),
    .dc_wdata2_pyro  (w2),
    .dc_we_pyro      (dc_we),
    .busy_pyro       (busy)
  );

  // Array model: registered read of idx and idx+1, paired write, wrapping at 2048 words.
  always @(posedge clk) begin
    if (dc_rd) begin
      rd1 <= mem[dc_idx];
      rd2 <= mem[dc_idx + 11'd1];
    end
    if (dc_we) begin
      mem[dc_idx]         <= w1;
      mem[dc_idx + 11'd1] <= w2;
      we_cnt              <= we_cnt + 1;
    end
    if (pl_we) mem[pl_idx] <= pl_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] idx, input logic [63:0] d);
    pl_we = 1'b1; pl_idx = idx; pl_data = d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic store_op(input string tag, input logic [63:0] addr, input logic [63:0] d,
                          input logic [2:0] f3, input logic legal,
                          input logic [63:0] ew1, input logic [63:0] ew2);
    int n0;
    n0 = we_cnt;
    req_addr = addr; req_data = d; req_f3 = f3; req_store = 1'b1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk({tag, ".rd"},    64'(dc_rd), 64'd1);
    chk({tag, ".idx"},   64'(dc_idx), 64'(addr[13:3]));
    chk({tag, ".retry"}, 64'(req_retry), 64'd1);
    step();
    chk({tag, ".capt_we"}, 64'(dc_we), 64'd0);
    step();
    if (legal) begin
      chk({tag, ".we"},  64'(dc_we), 64'd1);
      chk({tag, ".w1"},  w1, ew1);
      chk({tag, ".w2"},  w2, ew2);
      chk({tag, ".widx"}, 64'(dc_idx), 64'(addr[13:3]));
      step();
    end else begin
      chk({tag, ".no_we"}, 64'(dc_we), 64'd0);
    end
    chk({tag, ".idle"},  64'(req_retry), 64'd0);
    chk({tag, ".pulses"}, 64'(we_cnt - n0), 64'(legal));
  endtask

  task automatic load_op(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                         input int rc, input logic [63:0] exp);
    resp_retry = (rc > 0);
    req_addr = addr; req_data = 64'hdead_beef_dead_beef; req_f3 = f3; req_store = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk({tag, ".rd"},  64'(dc_rd), 64'd1);
    chk({tag, ".idx"}, 64'(dc_idx), 64'(addr[13:3]));
    step();
    chk({tag, ".early_v"}, 64'(resp_valid), 64'd0);
    step();
    for (int k = 0; k <= rc; k++) begin
      chk({tag, ".valid"}, 64'(resp_valid), 64'd1);
      chk({tag, ".data"},  resp_data, exp);
      chk({tag, ".busy"},  64'(req_retry), 64'd1);
      if (k == rc) resp_retry = 1'b0;
      step();
    end
    chk({tag, ".v_drop"}, 64'(resp_valid), 64'd0);
    chk({tag, ".idle"},   64'(req_retry), 64'd0);
  endtask

  initial begin
    int n0;
    #12;
    chk("rst.retry", 64'(req_retry), 64'd0);
    chk("rst.valid", 64'(resp_valid), 64'd0);
    chk("rst.data",  resp_data, 64'd0);
    chk("rst.rdwe",  64'({dc_rd, dc_we, busy}), 64'd0);
    chk("rst.idx",   64'(dc_idx), 64'd0);
    chk("rst.wdata", w1 | w2, 64'd0);
    rst_n = 1'b1;
    step();

    preload(11'd2, 64'd0);
    preload(11'd3, 64'd0);
    store_op("sd", 64'h10, 64'h1122_3344_5566_7788, 3'b011, 1'b1, 64'h1122_3344_5566_7788, 64'd0);
    preload(11'd3, 64'hffff_ffff_ffff_ffff);
    preload(11'd4, 64'hffff_ffff_ffff_ffff);
    store_op("sw", 64'h1d, 64'h0000_0000_aabb_ccdd, 3'b010, 1'b1,
             64'hbbcc_ddff_ffff_ffff, 64'hffff_ffff_ffff_ffaa);

    load_op("ld",  64'h10, 3'b011, 0, 64'h1122_3344_5566_7788);
    load_op("lw",  64'h1c, 3'b010, 0, 64'hffff_ffff_bbcc_ddff);
    load_op("lwu", 64'h1c, 3'b110, 1, 64'h0000_0000_bbcc_ddff);
    load_op("lh",  64'h1f, 3'b001, 0, 64'hffff_ffff_ffff_aabb);
    load_op("lhu", 64'h1f, 3'b101, 0, 64'h0000_0000_0000_aabb);

    preload(11'd0, 64'h80ff_ffff_ffff_ffff);
    preload(11'd1, 64'd0);
    load_op("lb",  64'h7, 3'b000, 3, 64'hffff_ffff_ffff_ff80);
    load_op("lbu", 64'h7, 3'b100, 0, 64'h0000_0000_0000_0080);

    preload(11'd2047, 64'h0123_4567_89ab_cdef);
    preload(11'd0,    64'hfedc_ba98_7654_3210);
    load_op("ld_wrap", 64'h3fff, 3'b011, 0, 64'hdcba_9876_5432_1001);
    store_op("sh_wrap", 64'h3fff, 64'h0000_0000_0000_beef, 3'b001, 1'b1,
             64'hef23_4567_89ab_cdef, 64'hfedc_ba98_7654_32be);

    load_op("ld_bad", 64'h10, 3'b111, 0, 64'd0);
    store_op("st_bad", 64'h10, 64'h5555_5555_5555_5555, 3'b100, 1'b0, 64'd0, 64'd0);
    load_op("ld_keep", 64'h10, 3'b011, 0, 64'h1122_3344_5566_7788);

    // Two stores with valid held high; a data change while busy must be ignored.
    preload(11'd8, 64'd0);
    preload(11'd9, 64'd0);
    n0 = we_cnt;
    req_addr = 64'h40; req_data = 64'h5a; req_f3 = 3'b000; req_store = 1'b1; req_valid = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("b2b.retry%0d", k), 64'(req_retry), 64'((k % 4) != 0));
      if (k == 5) req_data = 64'ha5;
      if (k < 8) step();
    end
    req_valid = 1'b0;
    step();
    chk("b2b.pulses", 64'(we_cnt - n0), 64'd2);
    load_op("b2b_lbu", 64'h40, 3'b100, 0, 64'h0000_0000_0000_005a);

    // Reset during CAPT of a store.
    preload(11'd16, 64'h0f0f_0f0f_0f0f_0f0f);
    preload(11'd17, 64'd0);
    n0 = we_cnt;
    req_addr = 64'h80; req_data = 64'hdead_dead_dead_dead; req_f3 = 3'b011; req_store = 1'b1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("mrst.in_capt", 64'({dc_rd, dc_we, busy}), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst.ctl",  64'({req_retry, busy, dc_rd, dc_we, resp_valid}), 64'd0);
    chk("mrst.idx",  64'(dc_idx), 64'd0);
    chk("mrst.wd",   w1 | w2 | resp_data, 64'd0);
    step();
    step();
    chk("mrst.no_we", 64'(we_cnt - n0), 64'd0);
    rst_n = 1'b1;
    step();
    chk("mrst.idle", 64'({req_retry, busy}), 64'd0);
    load_op("mrst_ld", 64'h80, 3'b011, 0, 64'h0f0f_0f0f_0f0f_0f0f);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pyrm_dcache_rmw_ctrl.md
# pyrm_dcache_rmw_ctrl

Sequencing controller for the write-back stage's two-word dcache array. It accepts one load or store at a time over a valid/retry handshake and splits each access into read, merge and write steps so that byte, half, word and double accesses at any byte offset are handled correctly. This includes accesses that straddle two adjacent 64-bit words. Load results return over a separate valid/retry channel to the write-back/register path.

## Interface
Parameters:
- DC_IDX_W, 11, dcache word-index width; the index is taken from req_addr_pyri[DC_IDX_W+2:3].

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_pyri  in  1  asynchronous, active-low reset.
- req_addr_pyri  in  64  byte address of the access.
- req_data_pyri  in  64  store data, right-aligned.
- req_f3_pyri  in  3  RV64 funct3 of the load or store.
- req_store_pyri  in  1  1 = store, 0 = load.
- req_valid_pyri  in  1  request valid.
- req_retry_pyro  out  1  request stall; a transfer occurs when valid=1 and retry=0.
- resp_data_pyro  out  64  load result, extended per funct3.
- resp_valid_pyro  out  1  load result valid.
- resp_retry_pyri  in  1  consumer stall on the response.
- dc_idx_pyro  out  DC_IDX_W  dcache word index; the array also returns index+1, wrapping modulo 2^DC_IDX_W.
- dc_rd_pyro  out  1  read strobe; data returns on the next cycle.
- dc_rdata1_pyri, dc_rdata2_pyri  in  64 each  words at idx and idx+1.
- dc_wdata1_pyro, dc_wdata2_pyro  out  64 each  merged write words.
- dc_we_pyro  out  1  write strobe for both words, at dc_idx_pyro.
- busy_pyro  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE: req_retry_pyro=0. On transfer, latch addr, data, f3 and store; go to READ.
  - READ: assert dc_rd_pyro with the latched index; go to CAPT.
  - CAPT: register {dc_rdata2_pyri, dc_rdata1_pyri} as a 128-bit line.
    - Store: go to WRITE.
    - Load: compute the result into resp_data_pyro and go to RESP.
  - WRITE: assert dc_we_pyro for exactly one cycle with the merged words; go to IDLE.
  - RESP: hold resp_valid_pyro=1 with resp_data_pyro stable; go to IDLE in the cycle resp_retry_pyri=0.
- req_retry_pyro = (state != IDLE). Only one access is in flight; no bypass or forwarding is needed.
- Size is decoded from f3[1:0]: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 8 bytes. off = addr[2:0].
- Store merge on the 128-bit line L:
  - mask = (2^(8·size) − 1) << (8·off).
  - new = (L & ~mask) | ((data << 8·off) & mask).
  - dc_wdata1_pyro = new[63:0]; dc_wdata2_pyro = new[127:64].
- Load extract:
  - x = L >> 8·off.
  - LB/LH/LW sign-extend from bit 8·size−1.
  - LBU/LHU/LWU zero-extend.
  - LD returns x[63:0].
- Illegal funct3 values are store f3[2]=1 and load f3=3'b111.
  - Illegal store: the request is accepted and WRITE is skipped (READ → CAPT → IDLE). dc_we_pyro never asserts.
  - Illegal load: returns resp_data_pyro=0 via RESP.
- Index wrap: idx = 2^DC_IDX_W−1 with off+size > 8 touches words 2047 and 0. Wrapping is handled by the array; the controller needs no special case.

## Timing
- Reset values: state=IDLE, req_retry_pyro=0, resp_valid_pyro=0, resp_data_pyro=0, dc_rd_pyro=0, dc_we_pyro=0, dc_idx_pyro=0, dc_wdata*=0, busy_pyro=0.
- Store latency: accepted at edge T; dc_rd_pyro high in cycle T+1; data captured at T+2; dc_we_pyro high in cycle T+3; next request accepted at T+4.
- Load latency: resp_valid_pyro rises in cycle T+3. With resp_retry_pyri=0, the next request is accepted at T+4.
- Response backpressure: while resp_retry_pyri=1, resp_valid_pyro and resp_data_pyro hold unchanged and req_retry_pyro stays 1.
- Reset asserted mid-operation: all outputs clear immediately (asynchronously). A store reset before or during WRITE either does not write or completes only a partial cycle. The array must treat dc_we_pyro deasserting mid-cycle as no write.
- The request inputs are sampled only in IDLE. Changes on them while busy are ignored.

## Structure
- Package pyrm_dcache_pkg holds:
  - the state enum (IDLE, READ, CAPT, WRITE, RESP);
  - a size-decode function;
  - the existing FUNCT3_LOAD_*/FUNCT3_STORE_* constants from rv64.vh.
- Sub-module pyrm_dcache_align is purely combinational: given line, off, f3 and data, it produces the merged 128-bit line and the extended load result. The controller instantiates it once.

## Test plan
- SD, addr 0x10, data 0x1122334455667788, words pre-loaded to 0 -> dc_we_pyro in cycle T+3 with idx=2, wdata1=0x1122334455667788, wdata2=0.
- SW, addr 0x1D (off=5), data 0xAABBCCDD, line all 0xFF -> wdata1=0xBBCCDDFFFFFFFFFF, wdata2=0xFFFFFFFFFFFFFFAA, idx=3.
- LB, addr 0x7, word0=0x80FF..., resp_retry_pyri=1 for 3 cycles -> resp_valid_pyro held 4 cycles with resp_data_pyro=0xFFFFFFFFFFFFFF80. Repeat as LBU -> 0x80.
- LD, addr 0x3FFF (idx=2047, off=7) -> dc_idx_pyro=2047. Result = {rdata2[55:0], rdata1[63:56]}.
- Back-to-back valid requests -> req_retry_pyro=1 for 3 cycles after each acceptance; exactly one dc_we_pyro pulse per legal store; none for store f3=3'b100.
- reset_pyri driven low during the CAPT cycle of a store -> all outputs 0 at once, no dc_we_pyro pulse. After release, state=IDLE and req_retry_pyro=0.
